// File: rtl/u409_cycle_decode_ctl.sv
// u409_cycle_decode_ctl: registered cycle tracker and region decoder for the U409 path.
// A bus cycle is captured on the first IDLE edge with nAS low. Region flags come from the
// captured values only, and CIA selects are timed by setup/recovery counts with a hang guard.
module u409_cycle_decode_ctl #(
  parameter int unsigned NUM_CIA      = 2,
  parameter logic [7:0]  IDE_BASE     = 8'hDA,
  parameter int unsigned SETUP_CLKS   = 2,
  parameter int unsigned RECOVER_CLKS = 3,
  parameter int unsigned TIMEOUT_CLKS = 255
) (
  input  logic               CLK40,
  input  logic               RESET,
  input  logic [31:12]       A,
  input  logic               nAS,
  input  logic               RnW,
  input  logic               OVL,
  input  logic               CIA_ENABLE,
  output logic               ROMEN,
  output logic               CIA_SPACE,
  output logic               IDE_SPACE,
  output logic [NUM_CIA-1:0] nCIACS,
  output logic               AUTOBOOT,
  output logic               TIMEOUT,
  output logic               BUSY
);

  localparam logic [7:0] SetupLast   = 8'(SETUP_CLKS - 1);
  localparam logic [7:0] RecoverLast = 8'(RECOVER_CLKS - 1);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StActive, StRecover} state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 autoboot_q, autoboot_d;
  logic                 timeout_q, timeout_d;
  logic                 capture;
  logic [31:16]         a_q;
  logic [NUM_CIA-1:0]   cia_sel_q;
  logic                 rnw_q, ovl_q, cia_en_q;
  logic                 z2_hit, rom_hit, cia_hit, ide_hit, in_cycle;

  // Select bits above NUM_CIA are intentionally ignored.
  logic unused_a;
  assign unused_a = ^A[15:12];

  // State, counter, overlay flag and captured cycle attributes.
  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      autoboot_q <= 1'b1;
      timeout_q  <= 1'b0;
      a_q        <= '0;
      cia_sel_q  <= '0;
      rnw_q      <= 1'b1;
      ovl_q      <= 1'b0;
      cia_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      autoboot_q <= autoboot_d;
      timeout_q  <= timeout_d;
      if (capture) begin
        a_q       <= A[31:16];
        cia_sel_q <= A[12 +: NUM_CIA];
        rnw_q     <= RnW;
        ovl_q     <= OVL;
        cia_en_q  <= CIA_ENABLE;
      end
    end
  end

  // Region decode from the captured address only.
  always_comb begin
    z2_hit  = (a_q[31:24] == 8'h00);
    rom_hit = z2_hit && ((ovl_q && (a_q[23:21] == 3'b000)) ||
                         (!ovl_q && (a_q[23:20] == 4'hF)));
    cia_hit = z2_hit && (a_q[23:16] == 8'hBF);
    ide_hit = z2_hit && (a_q[23:16] == IDE_BASE);
  end

  // Next-state: one shared counter times SETUP, ACTIVE (hang guard) and RECOVER.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    autoboot_d = autoboot_q;
    timeout_d  = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!nAS) begin
          capture = 1'b1;
          state_d = StSetup;
          cnt_d   = '0;
        end
      end
      StSetup: begin
        if (nAS) begin
          state_d = StRecover;
          cnt_d   = '0;
        end else if (cnt_q == SetupLast) begin
          state_d = StActive;
          cnt_d   = '0;
          // A write to the IDE window hands IDE reads back to the drive.
          if (!rnw_q && ide_hit) autoboot_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StActive: begin
        if (nAS) begin
          state_d = StRecover;
          cnt_d   = '0;
        end else if (cnt_q >= TimeoutLast) begin
          state_d   = StRecover;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRecover: begin
        if (cnt_q == RecoverLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: region flags through SETUP/ACTIVE, selects only in ACTIVE.
  always_comb begin
    in_cycle  = (state_q == StSetup) || (state_q == StActive);
    ROMEN     = in_cycle && (rom_hit || (ide_hit && rnw_q && autoboot_q));
    IDE_SPACE = in_cycle && ide_hit && (!rnw_q || !autoboot_q);
    CIA_SPACE = in_cycle && cia_hit;
    nCIACS    = '1;
    if ((state_q == StActive) && cia_hit && cia_en_q) nCIACS = ~cia_sel_q;
    AUTOBOOT  = autoboot_q;
    TIMEOUT   = timeout_q;
    BUSY      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_u409_cycle_decode_ctl.sv
// Scoreboard bench for u409_cycle_decode_ctl: the driver predicts each bus cycle from the
// decode/timing rules and queues it; a negedge monitor pops and checks as cycles appear.
module tb_u409_cycle_decode_ctl;

  localparam int S = 2;
  localparam int R = 3;
  localparam int T = 255;

  logic         CLK40 = 1'b0;
  logic         RESET = 1'b1;
  logic [31:12] A = '0;
  logic         nAS = 1'b1, RnW = 1'b1, OVL = 1'b0, CIA_ENABLE = 1'b0;
  logic         ROMEN, CIA_SPACE, IDE_SPACE, AUTOBOOT, TIMEOUT, BUSY;
  logic [1:0]   nCIACS;
  logic         ROMEN4, CIA_SPACE4, IDE_SPACE4, AUTOBOOT4, TIMEOUT4, BUSY4;
  logic [3:0]   nCIACS4;

  always #5 CLK40 = ~CLK40;

  u409_cycle_decode_ctl #(.NUM_CIA(2)) dut (
    .CLK40(CLK40), .RESET(RESET), .A(A), .nAS(nAS), .RnW(RnW), .OVL(OVL),
    .CIA_ENABLE(CIA_ENABLE), .ROMEN(ROMEN), .CIA_SPACE(CIA_SPACE), .IDE_SPACE(IDE_SPACE),
    .nCIACS(nCIACS), .AUTOBOOT(AUTOBOOT), .TIMEOUT(TIMEOUT), .BUSY(BUSY)
  );

  u409_cycle_decode_ctl #(.NUM_CIA(4)) dut4 (
    .CLK40(CLK40), .RESET(RESET), .A(A), .nAS(nAS), .RnW(RnW), .OVL(OVL),
    .CIA_ENABLE(CIA_ENABLE), .ROMEN(ROMEN4), .CIA_SPACE(CIA_SPACE4), .IDE_SPACE(IDE_SPACE4),
    .nCIACS(nCIACS4), .AUTOBOOT(AUTOBOOT4), .TIMEOUT(TIMEOUT4), .BUSY(BUSY4)
  );

  typedef struct {
    logic       romen, cia, ide;
    logic [1:0] ncs2;
    logic [3:0] ncs4;
    int         busy;
    int         active;
    bit         tmo;
    logic       ab_after;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic ab_model = 1'b1;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decode rules plus cycle length derived from how long nAS is held (h edges).
  function automatic exp_t predict(input logic [31:12] a, input logic rnw, input logic ovl,
                                   input logic en, input int h);
    exp_t e;
    logic z2, rom, ide_hit, cia;
    z2      = (a[31:24] == 8'h00);
    rom     = z2 && ((ovl && a[23:21] == 3'd0) || (!ovl && a[23:20] == 4'hF));
    ide_hit = z2 && (a[23:16] == 8'hDA);
    cia     = z2 && (a[23:16] == 8'hBF);
    e.romen = rom || (ide_hit && rnw && ab_model);
    e.ide   = ide_hit && (!rnw || !ab_model);
    e.cia   = cia;
    if (h <= S) begin
      e.active = 0; e.tmo = 1'b0; e.busy = h + R;
    end else if (h - S > T) begin
      e.active = T; e.tmo = 1'b1; e.busy = S + T + R;
    end else begin
      e.active = h - S; e.tmo = 1'b0; e.busy = h + R;
    end
    e.ncs2 = 2'b11;
    e.ncs4 = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      if (e.active > 0 && cia && en && a[12+n]) begin
        e.ncs4[n] = 1'b0;
        if (n < 2) e.ncs2[n] = 1'b0;
      end
    end
    if (e.active > 0 && !rnw && ide_hit) ab_model = 1'b0;
    e.ab_after = ab_model;
    return e;
  endfunction

  task automatic do_cycle(input logic [31:12] a, input logic rnw, input logic ovl,
                          input logic en, input int h, input int gap);
    exp_t e;
    e = predict(a, rnw, ovl, en, h);
    sb_q.push_back(e);
    @(posedge CLK40); #1;
    A = a; RnW = rnw; OVL = ovl; CIA_ENABLE = en; nAS = 1'b0;
    repeat (h) @(posedge CLK40);
    #1;
    nAS = 1'b1;
    // Scramble inputs mid-cycle; only the captured copy may matter.
    A = 20'($urandom); RnW = 1'($urandom); OVL = 1'($urandom); CIA_ENABLE = 1'($urandom);
    repeat (e.busy - h + 1 + gap) @(posedge CLK40);
  endtask

  // Monitor
  exp_t       cur;
  bit         prev_busy = 1'b0;
  int         idx, lowcnt, first_low, tcnt, tidx;
  logic [1:0] cs_and;
  logic [3:0] cs4_and;

  always @(negedge CLK40) begin
    if (mon_en) begin
      if (BUSY && !prev_busy) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_cycle", 32'd1, 32'd0);
          cur = '{1'b0, 1'b0, 1'b0, 2'b11, 4'hF, 0, 0, 1'b0, ab_model};
        end else begin
          cur = sb_q.pop_front();
        end
        idx = 0; lowcnt = 0; first_low = 0; tcnt = 0; tidx = 0;
        cs_and = 2'b11; cs4_and = 4'hF;
      end
      if (BUSY) begin
        idx++;
        if (idx <= cur.busy - R)
          chk("regions", {29'd0, ROMEN, CIA_SPACE, IDE_SPACE}, {29'd0, cur.romen, cur.cia, cur.ide});
        else
          chk("regions_recover", {29'd0, ROMEN, CIA_SPACE, IDE_SPACE}, 32'd0);
        if (nCIACS != 2'b11) begin
          lowcnt++;
          if (first_low == 0) first_low = idx;
        end
        cs_and  = cs_and & nCIACS;
        cs4_and = cs4_and & nCIACS4;
        if (TIMEOUT) begin
          tcnt++;
          tidx = idx;
        end
      end else begin
        if (prev_busy) begin
          chk("busy_len", 32'(idx), 32'(cur.busy));
          chk("ncs2", {30'd0, cs_and}, {30'd0, cur.ncs2});
          chk("ncs4", {28'd0, cs4_and}, {28'd0, cur.ncs4});
          chk("cs_low_len", 32'(lowcnt), (cur.ncs2 != 2'b11) ? 32'(cur.active) : 32'd0);
          chk("cs_first", 32'(first_low), (cur.ncs2 != 2'b11) ? 32'(S + 1) : 32'd0);
          chk("timeout_cnt", 32'(tcnt), {31'd0, cur.tmo});
          if (cur.tmo) chk("timeout_pos", 32'(tidx), 32'(S + T + 1));
          chk("autoboot", {31'd0, AUTOBOOT}, {31'd0, cur.ab_after});
        end
        chk("idle_quiet", {26'd0, ROMEN, CIA_SPACE, IDE_SPACE, TIMEOUT, ~&nCIACS, ~&nCIACS4},
            32'd0);
      end
      prev_busy = BUSY;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:12] a;
    int           h;
    repeat (3) @(posedge CLK40);
    #1;
    chk("reset_outs", {25'd0, ROMEN, CIA_SPACE, IDE_SPACE, nCIACS, TIMEOUT, BUSY},
        {25'd0, 3'b000, 2'b11, 2'b00});
    chk("reset_autoboot", {31'd0, AUTOBOOT}, 32'd1);
    RESET = 1'b0;
    mon_en = 1'b1;

    // Directed cycles
    do_cycle(20'h00BFE, 1'b1, 1'b0, 1'b1, 6, 0);     // CIA read, A13 select
    do_cycle(20'h00000, 1'b1, 1'b1, 1'b1, 4, 1);     // overlay ROM
    do_cycle(20'h00000, 1'b1, 1'b0, 1'b1, 4, 0);     // no overlay
    do_cycle(20'h00F80, 1'b1, 1'b0, 1'b1, 4, 0);     // high ROM
    do_cycle(20'h00DA0, 1'b1, 1'b0, 1'b1, 4, 0);     // IDE read via autoboot ROM
    do_cycle(20'h00DA2, 1'b0, 1'b0, 1'b1, 5, 0);     // IDE write clears autoboot
    do_cycle(20'h00DA0, 1'b1, 1'b0, 1'b1, 4, 0);     // IDE read now hits IDE
    do_cycle(20'h00BFD, 1'b1, 1'b0, 1'b1, 259, 0);   // hung cycle -> timeout
    do_cycle(20'h00BFF, 1'b1, 1'b0, 1'b1, 1, 0);     // abort from SETUP
    do_cycle(20'h00BFE, 1'b1, 1'b0, 1'b0, 6, 0);     // CIA disabled
    do_cycle(20'h01BFE, 1'b1, 1'b0, 1'b1, 6, 0);     // not Z2
    do_cycle(20'h00BFA, 1'b0, 1'b0, 1'b1, 6, 2);     // four-select pattern

    // Randomized cycles
    for (int i = 0; i < 150; i++) begin
      case ($urandom % 6)
        0: a = {8'h00, 8'hBF, 4'($urandom)};
        1: a = {8'h00, 8'hDA, 4'($urandom)};
        2: a = {8'h00, 3'b000, 9'($urandom)};
        3: a = {8'h00, 4'hF, 8'($urandom)};
        4: a = {8'($urandom_range(1, 255)), 8'hBF, 4'($urandom)};
        default: a = 20'($urandom);
      endcase
      if ($urandom % 12 == 0) h = 258 + $urandom_range(0, 2);
      else h = $urandom_range(1, 12);
      do_cycle(a, 1'($urandom), 1'($urandom), ($urandom % 4) != 0, h, $urandom_range(0, 3));
    end

    for (int k = 0; k < 1000 && (sb_q.size() != 0 || prev_busy); k++) @(posedge CLK40);
    chk("drain", 32'(sb_q.size()), 32'd0);
    mon_en = 1'b0;

    // Reset in the middle of an ACTIVE CIA cycle
    @(posedge CLK40); #1;
    A = 20'h00BFE; RnW = 1'b1; OVL = 1'b0; CIA_ENABLE = 1'b1; nAS = 1'b0;
    repeat (4) @(posedge CLK40);
    #1;
    chk("pre_reset_cs", {30'd0, nCIACS}, 32'h1);
    chk("pre_reset_autoboot", {31'd0, AUTOBOOT}, {31'd0, ab_model});
    RESET = 1'b1;
    @(posedge CLK40); #1;
    ab_model = 1'b1;
    chk("mid_reset_outs", {21'd0, ROMEN, CIA_SPACE, IDE_SPACE, nCIACS, nCIACS4, TIMEOUT, BUSY},
        {21'd0, 3'b000, 2'b11, 4'hF, 2'b00});
    chk("mid_reset_autoboot", {31'd0, AUTOBOOT}, {31'd0, ab_model});
    RESET = 1'b0;
    nAS = 1'b1;
    @(posedge CLK40); #1;
    chk("post_reset_idle", {31'd0, BUSY}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
